// File: rtl/gpu_pkg.sv
// Widths and colour types shared by the palette memory, stage 4 and stage 5.
// The output FIFO depth is fixed here so both sides agree on it.
package gpu_pkg;

    localparam int IDX_W          = 10;
    localparam int COL_W          = 16;
    localparam int OUT_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/palette_out_fifo.sv
// Two-entry output FIFO between the palette lookup and display output.
// Head entry is presented combinationally; outputs read zero while empty.
module palette_out_fifo
    import gpu_pkg::*;
#(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [1:0] DEPTH = 2'(OUT_FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && (r_count != DEPTH);
    assign w_pop  = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == DEPTH);
    assign o_data  = o_valid ? r_mem[r_head] : '0;

endmodule

// File: rtl/palette_lookup.sv
// Stage 4 front end: palette lookup of index pairs plus host write arbitration
// on the shared write/read-1 port of the palette memory.
module palette_lookup #(
    parameter int IDX_W        = gpu_pkg::IDX_W,
    parameter int COL_W        = gpu_pkg::COL_W,
    parameter int STARVE_LIMIT = 15,
    parameter bit TRANSP_EN    = 1'b1,
    parameter int TRANSP_IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [IDX_W-1:0] pix_idx0,
    input  logic [IDX_W-1:0] pix_idx1,
    input  logic             pix_last,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [COL_W-1:0] wr_data,
    output logic             pal_we,
    output logic [IDX_W-1:0] pal_addr1,
    output logic [IDX_W-1:0] pal_addr2,
    output logic [COL_W-1:0] pal_wdata,
    input  logic [COL_W-1:0] pal_rdata1,
    input  logic [COL_W-1:0] pal_rdata2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] out_px0,
    output logic [COL_W-1:0] out_px1,
    output logic [1:0]       out_transp,
    output logic             out_last
);

    localparam int         FIFO_W = 2 * COL_W + 3;
    localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);
    localparam logic [IDX_W-1:0] T_IDX = IDX_W'(TRANSP_IDX);

    logic [7:0]        r_starve;
    logic              w_force;
    logic              w_full;
    logic              w_grant;
    logic              w_push;
    logic [1:0]        w_transp;
    logic [FIFO_W-1:0] w_in;
    logic [FIFO_W-1:0] w_out;

    // A starved write steals exactly one slot from the pixel stream.
    assign w_force = wr_valid && (r_starve == LIMIT);

    // Gated by rst so nothing reaches the memory while held in reset.
    assign w_grant   = rst && wr_valid && (!pix_valid || w_full || w_force);
    assign pix_ready = rst && !w_full && !w_force;
    assign wr_ready  = w_grant;
    assign w_push    = pix_valid && pix_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= 8'd0;
        end else if (!wr_valid || w_grant) begin
            r_starve <= 8'd0;
        end else if (r_starve != LIMIT) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    assign pal_we    = w_grant;
    assign pal_addr1 = w_grant ? wr_addr : pix_idx0;
    assign pal_addr2 = pix_idx1;
    assign pal_wdata = wr_data;

    assign w_transp[0] = TRANSP_EN && (pix_idx0 == T_IDX);
    assign w_transp[1] = TRANSP_EN && (pix_idx1 == T_IDX);

    assign w_in = {pix_last, w_transp, pal_rdata2, pal_rdata1};

    palette_out_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_full  (w_full),
        .o_data  (w_out)
    );

    assign {out_last, out_transp, out_px1, out_px0} = w_out;

endmodule

// File: tb/tb_palette_lookup.sv
// Bench for palette_lookup: directed scenarios plus a randomized stream
// checked against a queue-based model of the lookup stage.
module tb_palette_lookup;
    import gpu_pkg::*;

    localparam int SL = 15;
    localparam rgb565_t RED   = '{r: 5'h1F, g: 6'h00, b: 5'h00};
    localparam rgb565_t GREEN = '{r: 5'h00, g: 6'h3F, b: 5'h00};
    localparam rgb565_t BLUE  = '{r: 5'h00, g: 6'h00, b: 5'h1F};

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic [9:0]  pix_idx0;
    logic [9:0]  pix_idx1;
    logic        pix_last;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        out_ready;

    wire         pix_ready;
    wire         wr_ready;
    wire         pal_we;
    wire  [9:0]  pal_addr1;
    wire  [9:0]  pal_addr2;
    wire  [15:0] pal_wdata;
    wire  [15:0] pal_rdata1;
    wire  [15:0] pal_rdata2;
    wire         out_valid;
    wire  [15:0] out_px0;
    wire  [15:0] out_px1;
    wire  [1:0]  out_transp;
    wire         out_last;

    wire         d0_pix_ready;
    wire         d0_wr_ready;
    wire         d0_pal_we;
    wire  [9:0]  d0_pal_addr1;
    wire  [9:0]  d0_pal_addr2;
    wire  [15:0] d0_pal_wdata;
    wire         d0_out_valid;
    wire  [15:0] d0_out_px0;
    wire  [15:0] d0_out_px1;
    wire  [1:0]  d0_out_transp;
    wire         d0_out_last;

    palette_lookup #(
        .STARVE_LIMIT (SL),
        .TRANSP_EN    (1'b1),
        .TRANSP_IDX   (0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_idx0   (pix_idx0),
        .pix_idx1   (pix_idx1),
        .pix_last   (pix_last),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pal_we     (pal_we),
        .pal_addr1  (pal_addr1),
        .pal_addr2  (pal_addr2),
        .pal_wdata  (pal_wdata),
        .pal_rdata1 (pal_rdata1),
        .pal_rdata2 (pal_rdata2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_px0    (out_px0),
        .out_px1    (out_px1),
        .out_transp (out_transp),
        .out_last   (out_last)
    );

    palette_lookup #(
        .STARVE_LIMIT (SL),
        .TRANSP_EN    (1'b0),
        .TRANSP_IDX   (0)
    ) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (d0_pix_ready),
        .pix_idx0   (pix_idx0),
        .pix_idx1   (pix_idx1),
        .pix_last   (pix_last),
        .wr_valid   (wr_valid),
        .wr_ready   (d0_wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pal_we     (d0_pal_we),
        .pal_addr1  (d0_pal_addr1),
        .pal_addr2  (d0_pal_addr2),
        .pal_wdata  (d0_pal_wdata),
        .pal_rdata1 (pal_rdata1),
        .pal_rdata2 (pal_rdata2),
        .out_valid  (d0_out_valid),
        .out_ready  (out_ready),
        .out_px0    (d0_out_px0),
        .out_px1    (d0_out_px1),
        .out_transp (d0_out_transp),
        .out_last   (d0_out_last)
    );

    function automatic logic [15:0] init_col(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Palette memory: synchronous write, combinational reads.
    logic [15:0] pal [1024];
    initial begin
        for (int i = 0; i < 1024; i++) pal[i] = init_col(i);
        forever begin
            @(posedge clk);
            if (pal_we === 1'b1) pal[pal_addr1] <= pal_wdata;
        end
    end
    assign pal_rdata1 = pal[pal_addr1];
    assign pal_rdata2 = pal[pal_addr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p0;
        logic [15:0] p1;
        logic [1:0]  tr;
        logic        last;
    } ent_t;

    ent_t        q[$];
    logic [15:0] ref_pal [1024];
    int          m_starve;
    logic        e_wr;
    logic        e_pr;
    int          checks;
    int          errors;

    task automatic apply(input logic pv, input logic [9:0] i0,
                         input logic [9:0] i1, input logic lst,
                         input logic wv, input logic [9:0] wa,
                         input logic [15:0] wd, input logic ordy);
        logic frc;
        @(negedge clk);
        pix_valid = pv;
        pix_idx0  = i0;
        pix_idx1  = i1;
        pix_last  = lst;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        out_ready = ordy;
        #1;
        frc  = wv && (m_starve == SL);
        e_wr = wv && (!pv || q.size() == 2 || frc);
        e_pr = (q.size() < 2) && !frc;
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (pix_valid && e_pr) begin
            e.p0   = ref_pal[pix_idx0];
            e.p1   = ref_pal[pix_idx1];
            e.tr   = {pix_idx1 == 10'd0, pix_idx0 == 10'd0};
            e.last = pix_last;
            q.push_back(e);
        end
        if (e_wr) ref_pal[wr_addr] = wr_data;
        if (!wr_valid || e_wr) m_starve = 0;
        else if (m_starve < SL) m_starve++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pix_valid = 1'b1; pix_idx0 = 10'd1; pix_idx1 = 10'd2;
        pix_last = 1'b1; wr_valid = 1'b1; wr_addr = 10'd4;
        wr_data = 16'hFFFF; out_ready = 1'b1;
        #3;
        checks++;
        if ({out_valid, out_px0, out_px1, out_transp, out_last, pal_we} !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b px0=%h px1=%h tr=%b last=%b we=%b required all 0",
                     out_valid, out_px0, out_px1, out_transp, out_last, pal_we);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0; wr_valid = 1'b0;
        rst = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_idle_write();
        logic [9:0]  a [2];
        logic [15:0] d [2];
        a[0] = 10'd5; d[0] = RED;
        a[1] = 10'd9; d[1] = GREEN;
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, a[k], d[k], 1'b1);
            checks++;
            if (wr_ready !== 1'b1 || pal_we !== 1'b1 || pal_addr1 !== a[k]
                || pal_wdata !== d[k]) begin
                errors++;
                $display("FAIL idle_write rdy=%b we=%b addr=%h data=%h required 1 1 %h %h",
                         wr_ready, pal_we, pal_addr1, pal_wdata, a[k], d[k]);
            end
            tick();
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 9; k++) begin
            if (k < 8)
                apply(1'b1, 10'd5, 10'd9, k == 7, 1'b0, 10'd0, 16'd0, 1'b1);
            else
                apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
            if (k < 8) begin
                checks++;
                if (pix_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_bubble beat=%0d pix_ready=%b required 1", k, pix_ready);
                end
            end
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_px0 !== RED || out_px1 !== GREEN
                    || out_last !== (k == 8)) begin
                    errors++;
                    $display("FAIL stream_beat beat=%0d v=%b px0=%h px1=%h last=%b required 1 %h %h %b",
                             k, out_valid, out_px0, out_px1, out_last, RED, GREEN, k == 8);
                end
            end
            tick();
        end
        apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain out_valid=%b required 0", out_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int acc;
        int got;
        acc = 0;
        got = 0;
        idle(2);
        for (int c = 0; c < 5; c++) begin
            apply(1'b1, 10'(20 + c), 10'(30 + c), 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
            checks++;
            if (pix_ready !== e_pr) begin
                errors++;
                $display("FAIL bp_ready cycle=%0d pix_ready=%b required %b", c, pix_ready, e_pr);
            end
            if (pix_ready === 1'b1) acc++;
            tick();
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepts got=%0d required 2", acc);
        end
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
            if (c < 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_px0 !== ref_pal[20 + c]
                    || out_px1 !== ref_pal[30 + c]) begin
                    errors++;
                    $display("FAIL bp_order pos=%0d v=%b px0=%h px1=%h required 1 %h %h",
                             c, out_valid, out_px0, out_px1, ref_pal[20 + c], ref_pal[30 + c]);
                end
            end
            if (out_valid === 1'b1) got++;
            tick();
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL bp_delivered got=%0d required 2", got);
        end
    endtask

    task automatic test_forced_write();
        int grant_at;
        grant_at = 0;
        idle(3);
        for (int c = 1; c <= 40 && grant_at == 0; c++) begin
            apply(1'b1, 10'(100 + c), 10'(200 + c), 1'b0, 1'b1, 10'd3, BLUE, 1'b1);
            checks++;
            if (pix_ready !== (c != SL + 1) || wr_ready !== (c == SL + 1)) begin
                errors++;
                $display("FAIL forced_hs cycle=%0d pix_ready=%b wr_ready=%b required %b %b",
                         c, pix_ready, wr_ready, c != SL + 1, c == SL + 1);
            end
            if (wr_ready === 1'b1) grant_at = c;
            tick();
        end
        checks++;
        if (grant_at != SL + 1) begin
            errors++;
            $display("FAIL forced_grant_cycle got=%0d required %0d", grant_at, SL + 1);
        end
        apply(1'b1, 10'd3, 10'd3, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL forced_one_bubble pix_ready=%b required 1", pix_ready);
        end
        tick();
        apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_px0 !== BLUE || out_px1 !== BLUE) begin
            errors++;
            $display("FAIL forced_raw v=%b px0=%h px1=%h required 1 %h %h",
                     out_valid, out_px0, out_px1, BLUE, BLUE);
        end
        tick();
    endtask

    task automatic test_transparency();
        idle(1);
        apply(1'b1, 10'd0, 10'd7, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        tick();
        apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b1);
        checks++;
        if (out_transp !== 2'b01 || out_px0 !== ref_pal[0] || out_px1 !== ref_pal[7]) begin
            errors++;
            $display("FAIL transp_en tr=%b px0=%h px1=%h required 01 %h %h",
                     out_transp, out_px0, out_px1, ref_pal[0], ref_pal[7]);
        end
        checks++;
        if (d0_out_transp !== 2'b00 || d0_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL transp_dis tr=%b v=%b required 00 1", d0_out_transp, d0_out_valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic        pend;
        logic [9:0]  pa;
        logic [15:0] pd;
        logic        pv;
        pend = 1'b0;
        pa = '0;
        pd = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pend && $urandom_range(0, 9) == 0) begin
                pend = 1'b1;
                pa = 10'($urandom_range(0, 15));
                pd = 16'($urandom);
            end
            pv = ($urandom_range(0, 9) < 8);
            apply(pv, 10'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
                  1'($urandom), pend, pa, pd, ($urandom_range(0, 9) < 6));
            checks++;
            if ({pix_ready, wr_ready, pal_we} !== {e_pr, e_wr, e_wr}) begin
                errors++;
                $display("FAIL rand_hs cycle=%0d pr/wr/we=%b%b%b required %b%b%b",
                         c, pix_ready, wr_ready, pal_we, e_pr, e_wr, e_wr);
            end
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid cycle=%0d out_valid=%b required %b",
                         c, out_valid, q.size() != 0);
            end else if (q.size() != 0) begin
                checks++;
                if ({out_px0, out_px1, out_transp, out_last}
                    !== {q[0].p0, q[0].p1, q[0].tr, q[0].last}) begin
                    errors++;
                    $display("FAIL rand_data cycle=%0d got %h %h %b %b required %h %h %b %b",
                             c, out_px0, out_px1, out_transp, out_last,
                             q[0].p0, q[0].p1, q[0].tr, q[0].last);
                end
            end
            if (e_wr) pend = 1'b0;
            tick();
        end
        idle(3);
    endtask

    task automatic test_reset_midstream();
        idle(1);
        apply(1'b1, 10'd40, 10'd41, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
        tick();
        apply(1'b1, 10'd42, 10'd43, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
        tick();
        apply(1'b1, 10'd44, 10'd45, 1'b0, 1'b1, 10'd6, 16'h1234, 1'b0);
        checks++;
        if (pix_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full pix_ready=%b out_valid=%b required 0 1", pix_ready, out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || pal_we !== 1'b0 || out_px0 !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset v=%b we=%b px0=%h required 0 0 0000",
                     out_valid, pal_we, out_px0);
        end
        q.delete();
        m_starve = 0;
        @(negedge clk);
        pix_valid = 1'b0;
        wr_valid  = 1'b0;
        rst = 1'b1;
        apply(1'b1, 10'd50, 10'd51, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
        tick();
        apply(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 16'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_px0 !== ref_pal[50] || out_px1 !== ref_pal[51]) begin
            errors++;
            $display("FAIL mid_first v=%b px0=%h px1=%h required 1 %h %h",
                     out_valid, out_px0, out_px1, ref_pal[50], ref_pal[51]);
        end
        tick();
        idle(2);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_starve = 0;
        for (int i = 0; i < 1024; i++) ref_pal[i] = init_col(i);
        test_reset();
        test_idle_write();
        test_stream();
        test_backpressure();
        test_forced_write();
        test_transparency();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
